// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the FIFO clients and fifo_ctrl.
// The master side drives requests; the slave (controller) drives RAM controls and flags.
interface fifo_ctrl_if #(
  parameter int unsigned DATA_DEPTH = 9
);
  logic                  flush;
  logic                  wr_req;
  logic                  rd_req;
  logic                  clr_err;
  logic                  ram_wr_en;
  logic [DATA_DEPTH-1:0] ram_waddr;
  logic                  ram_rd_en;
  logic [DATA_DEPTH-1:0] ram_raddr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DATA_DEPTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_req, rd_req, clr_err,
    input  ram_wr_en, ram_waddr, ram_rd_en, ram_raddr,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_req, rd_req, clr_err,
    output ram_wr_en, ram_waddr, ram_rd_en, ram_raddr,
    output full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller for a show-ahead fifo_ram.
// Flags are computed from next-state pointers and registered.
module fifo_ctrl #(
  parameter int unsigned DATA_DEPTH = 9,
  parameter int unsigned AF_LEVEL   = (1 << DATA_DEPTH) - 4,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_ctrl_if.slave bus
);

  localparam int unsigned PW = DATA_DEPTH + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wa_c, ra_c;

  // Acceptance, next pointers, and flags derived from the next pointers
  always_comb begin
    wa_c     = bus.wr_req & ~full_q & ~bus.flush;
    ra_c     = bus.rd_req & ~empty_q & ~bus.flush;
    wptr_d   = wptr_q + PW'(wa_c);
    rptr_d   = rptr_q + PW'(ra_c);
    ovf_d    = ovf_q & ~bus.clr_err;
    udf_d    = udf_q & ~bus.clr_err;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (bus.wr_req & full_q)  ovf_d = 1'b1;
      if (bus.rd_req & empty_q) udf_d = 1'b1;
    end
    count_d  = wptr_d - rptr_d;
    full_d   = (wptr_d[PW-1] != rptr_d[PW-1]) &&
               (wptr_d[DATA_DEPTH-1:0] == rptr_d[DATA_DEPTH-1:0]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (count_d >= PW'(AF_LEVEL));
    aempty_d = (count_d <= PW'(AE_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Enables are gated by reset so nothing reaches the RAM while rst_n is low
  assign bus.ram_wr_en    = wa_c & rst_n;
  assign bus.ram_rd_en    = ra_c & rst_n;
  assign bus.ram_waddr    = wptr_q[DATA_DEPTH-1:0];
  assign bus.ram_raddr    = rptr_q[DATA_DEPTH-1:0];
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
